proc_mem_arbiter: RTL and testbench

Parametrised memory interface unit between the processor's requesters (instruction fetch, data load/store, up to `NUM_PORTS` channels) and a single fixed-latency memory. It arbitrates requests round-robin and holds `READ`/`WRITE` for a configurable number of wait states. It returns read data with a one-cycle done pulse per channel. This replaces the direct single-cycle `READ`/`WRITE`/`ADDR`/`DATA_OUT` connection of the current processor top level.

---
 rtl/proc_mem_arbiter_if.sv | 40 ++++
 rtl/proc_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_proc_mem_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : proc_mem_arbiter_if
// Description : Requester channels plus single-memory bus seen by the
//               processor memory arbiter. The slave modport belongs to the
//               arbiter; the master modport is the requester/memory side.
// Revision    : 1.0 - initial release
// ============================================================================
interface proc_mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 26,
    parameter int NUM_PORTS  = 2
);
    // Requester side
    logic [NUM_PORTS-1:0]            p_req;
    logic [NUM_PORTS-1:0]            p_we;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] p_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] p_wdata;
    logic [NUM_PORTS-1:0]            p_gnt;
    logic [NUM_PORTS-1:0]            p_done;
    logic [DATA_WIDTH-1:0]           p_rdata;

    // Memory side
    logic [ADDR_WIDTH-1:0]           addr;
    logic [DATA_WIDTH-1:0]           data_out;
    logic [DATA_WIDTH-1:0]           data_in;
    logic                            read;
    logic                            write;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata, data_in,
        output p_gnt, p_done, p_rdata, addr, data_out, read, write
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata, data_in,
        input  p_gnt, p_done, p_rdata, addr, data_out, read, write
    );
endinterface
`default_nettype wire

// File: rtl/proc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : proc_mem_arbiter
// Description : Round-robin arbiter between NUM_PORTS requesters and one
//               fixed-latency memory. Holds READ/WRITE for WAIT_STATES+1
//               cycles, then pulses the channel's done bit and captures
//               read data. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_mem_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 26,
    parameter int NUM_PORTS   = 2,
    parameter int WAIT_STATES = 1
) (
    input wire                 clk,
    input wire                 rst,
    proc_mem_arbiter_if.slave  bus
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [IDX_W-1:0]       r_last;
    logic [NUM_PORTS-1:0]   r_sel;
    logic                   r_we;
    logic [3:0]             r_wait;

    logic [NUM_PORTS-1:0]   r_gnt;
    logic [NUM_PORTS-1:0]   r_done;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]  r_dout;
    logic                   r_read;
    logic                   r_write;

    logic                   w_found;
    logic [NUM_PORTS-1:0]   w_onehot;
    logic [IDX_W-1:0]       w_win;
    logic                   w_we;
    logic [ADDR_WIDTH-1:0]  w_addr;
    logic [DATA_WIDTH-1:0]  w_wdata;

    // Round-robin pick: scan offsets 1..NUM_PORTS from the last winner,
    // the first requesting channel at the smallest offset wins.
    always_comb begin
        w_found  = 1'b0;
        w_onehot = '0;
        w_win    = '0;
        w_we     = 1'b0;
        w_addr   = '0;
        w_wdata  = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            for (int c = 0; c < NUM_PORTS; c++) begin
                if (!w_found && bus.p_req[c] &&
                    (c == ((int'(r_last) + i) % NUM_PORTS))) begin
                    w_found     = 1'b1;
                    w_onehot[c] = 1'b1;
                    w_win       = IDX_W'(c);
                    w_we        = bus.p_we[c];
                    w_addr      = bus.p_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
                    w_wdata     = bus.p_wdata[c*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Next-state: accept any request in IDLE, finish when the counter is spent.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_found)         w_state_next = ACCESS;
            ACCESS:  if (r_wait == 4'd0)  w_state_next = IDLE;
            default:                      w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: latch the winner on accept, count wait states, complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last  <= IDX_W'(NUM_PORTS - 1);
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_wait  <= 4'd0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_rdata <= '0;
            r_addr  <= '0;
            r_dout  <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            if (r_state == IDLE) begin
                if (w_found) begin
                    r_last  <= w_win;
                    r_sel   <= w_onehot;
                    r_we    <= w_we;
                    r_addr  <= w_addr;
                    if (w_we) begin
                        r_dout <= w_wdata;
                    end
                    r_read  <= !w_we;
                    r_write <= w_we;
                    r_gnt   <= w_onehot;
                    r_wait  <= 4'(WAIT_STATES);
                end
            end else begin
                if (r_wait == 4'd0) begin
                    r_read  <= 1'b0;
                    r_write <= 1'b0;
                    r_done  <= r_sel;
                    if (!r_we) begin
                        r_rdata <= bus.data_in;
                    end
                end else begin
                    r_wait <= r_wait - 4'd1;
                end
            end
        end
    end

    assign bus.p_gnt    = r_gnt;
    assign bus.p_done   = r_done;
    assign bus.p_rdata  = r_rdata;
    assign bus.addr     = r_addr;
    assign bus.data_out = r_dout;
    assign bus.read     = r_read;
    assign bus.write    = r_write;

endmodule
`default_nettype wire

// File: tb/tb_proc_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_mem_arbiter
// Description : Drives two arbiters (2 ports / 1 wait state and 4 ports /
//               0 wait states) from shared stimulus and compares every cycle
//               against a transaction-level timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_mem_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 26;
    localparam int NPMAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Shared requester / memory stimulus
    logic [NPMAX-1:0] s_req = '0;
    logic [NPMAX-1:0] s_we  = '0;
    logic [AW-1:0]    s_addr  [NPMAX];
    logic [DW-1:0]    s_wdata [NPMAX];
    logic [DW-1:0]    s_din = '0;

    proc_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(2)) bus_a ();
    proc_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(4)) bus_b ();

    assign bus_a.p_req   = s_req[1:0];
    assign bus_a.p_we    = s_we[1:0];
    assign bus_a.p_addr  = {s_addr[1], s_addr[0]};
    assign bus_a.p_wdata = {s_wdata[1], s_wdata[0]};
    assign bus_a.data_in = s_din;

    assign bus_b.p_req   = s_req;
    assign bus_b.p_we    = s_we;
    assign bus_b.p_addr  = {s_addr[3], s_addr[2], s_addr[1], s_addr[0]};
    assign bus_b.p_wdata = {s_wdata[3], s_wdata[2], s_wdata[1], s_wdata[0]};
    assign bus_b.data_in = s_din;

    proc_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(2), .WAIT_STATES(1))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    proc_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_PORTS(4), .WAIT_STATES(0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    // Observed outputs, widened to common shapes
    logic [7:0]    obs_gnt  [2];
    logic [7:0]    obs_done [2];
    logic [AW-1:0] obs_addr [2];
    logic [DW-1:0] obs_dout [2];
    logic [DW-1:0] obs_rdata[2];
    logic          obs_rd   [2];
    logic          obs_wr   [2];

    assign obs_gnt[0]   = 8'(bus_a.p_gnt);
    assign obs_done[0]  = 8'(bus_a.p_done);
    assign obs_addr[0]  = bus_a.addr;
    assign obs_dout[0]  = bus_a.data_out;
    assign obs_rdata[0] = bus_a.p_rdata;
    assign obs_rd[0]    = bus_a.read;
    assign obs_wr[0]    = bus_a.write;
    assign obs_gnt[1]   = 8'(bus_b.p_gnt);
    assign obs_done[1]  = 8'(bus_b.p_done);
    assign obs_addr[1]  = bus_b.addr;
    assign obs_dout[1]  = bus_b.data_out;
    assign obs_rdata[1] = bus_b.p_rdata;
    assign obs_rd[1]    = bus_b.read;
    assign obs_wr[1]    = bus_b.write;

    // Timeline model: a transaction accepted at edge k strobes until
    // edge k+ws+1, where it completes; the unit is free again afterwards.
    typedef struct {
        int            np;
        int            ws;
        bit            busy;
        int            done_edge;
        int            ch;
        bit            we;
        int            last;
        logic [DW-1:0] rdata;
        logic [AW-1:0] addr;
        logic [DW-1:0] dout;
        bit            rd;
        bit            wr;
        logic [7:0]    gnt;
        logic [7:0]    done;
    } model_t;

    model_t m[2];
    int     edge_no = 0;
    bit     gnt_by[2][NPMAX];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_value(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset(int d);
        m[d].busy      = 1'b0;
        m[d].done_edge = 0;
        m[d].ch        = 0;
        m[d].we        = 1'b0;
        m[d].last      = m[d].np - 1;
        m[d].rdata     = '0;
        m[d].addr      = '0;
        m[d].dout      = '0;
        m[d].rd        = 1'b0;
        m[d].wr        = 1'b0;
        m[d].gnt       = '0;
        m[d].done      = '0;
    endtask

    task automatic model_step(int d);
        bit found;
        m[d].gnt  = '0;
        m[d].done = '0;
        if (m[d].busy) begin
            if (edge_no == m[d].done_edge) begin
                m[d].done = 8'(1) << m[d].ch;
                m[d].rd   = 1'b0;
                m[d].wr   = 1'b0;
                if (!m[d].we) m[d].rdata = s_din;
                m[d].busy = 1'b0;
            end
        end else begin
            found = 1'b0;
            for (int i = 1; i <= m[d].np; i++) begin
                int c;
                c = (m[d].last + i) % m[d].np;
                if (!found && s_req[c]) begin
                    found          = 1'b1;
                    m[d].last      = c;
                    m[d].ch        = c;
                    m[d].we        = s_we[c];
                    m[d].addr      = s_addr[c];
                    if (s_we[c]) m[d].dout = s_wdata[c];
                    m[d].rd        = !s_we[c];
                    m[d].wr        = s_we[c];
                    m[d].gnt       = 8'(1) << c;
                    m[d].done_edge = edge_no + m[d].ws + 1;
                    m[d].busy      = 1'b1;
                end
            end
        end
    endtask

    task automatic check_dut(int d);
        check_value($sformatf("d%0d_gnt", d),   64'(obs_gnt[d]),   64'(m[d].gnt));
        check_value($sformatf("d%0d_done", d),  64'(obs_done[d]),  64'(m[d].done));
        check_value($sformatf("d%0d_read", d),  64'(obs_rd[d]),    64'(m[d].rd));
        check_value($sformatf("d%0d_write", d), 64'(obs_wr[d]),    64'(m[d].wr));
        check_value($sformatf("d%0d_addr", d),  64'(obs_addr[d]),  64'(m[d].addr));
        check_value($sformatf("d%0d_dout", d),  64'(obs_dout[d]),  64'(m[d].dout));
        check_value($sformatf("d%0d_rdata", d), 64'(obs_rdata[d]), 64'(m[d].rdata));
        check_value($sformatf("d%0d_rw_excl", d), 64'(obs_rd[d] & obs_wr[d]), 64'(0));
    endtask

    // One clock: predict the coming edge, take it, check on the falling edge.
    task automatic run_cycle();
        model_step(0);
        model_step(1);
        @(posedge clk);
        edge_no++;
        @(negedge clk);
        check_dut(0);
        check_dut(1);
    endtask

    // Asynchronous reset pulse starting mid-cycle, released on a falling edge.
    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        check_dut(0);
        check_dut(1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic new_req(int c);
        s_req[c]   = 1'b1;
        s_we[c]    = 1'($urandom_range(0, 1));
        s_addr[c]  = AW'($urandom);
        s_wdata[c] = $urandom;
    endtask

    // Requesters hold each request until every DUT that sees the channel
    // has granted it, then drop it or immediately present a new one.
    task automatic update_stim();
        s_din = $urandom;
        for (int c = 0; c < NPMAX; c++) begin
            bit all_gnt;
            for (int d = 0; d < 2; d++) begin
                if (m[d].gnt[c]) gnt_by[d][c] = 1'b1;
            end
            all_gnt = gnt_by[1][c] && (c >= 2 || gnt_by[0][c]);
            if (!s_req[c]) begin
                if ($urandom_range(0, 3) == 0) new_req(c);
            end else if (all_gnt) begin
                gnt_by[0][c] = 1'b0;
                gnt_by[1][c] = 1'b0;
                if ($urandom_range(0, 1) == 1) new_req(c);
                else s_req[c] = 1'b0;
            end
        end
    endtask

    initial begin
        for (int c = 0; c < NPMAX; c++) begin
            s_addr[c]    = '0;
            s_wdata[c]   = '0;
            gnt_by[0][c] = 1'b0;
            gnt_by[1][c] = 1'b0;
        end
        m[0].np = 2; m[0].ws = 1;
        m[1].np = 4; m[1].ws = 0;

        // Reset asserted between edges; outputs must clear immediately.
        pulse_reset();
        for (int n = 0; n < 3; n++) run_cycle();

        // Single read on channel 0.
        s_din = 32'hDEADBEEF;
        s_req[0] = 1'b1; s_we[0] = 1'b0; s_addr[0] = 26'h0000010;
        run_cycle();
        s_req[0] = 1'b0;
        for (int n = 0; n < 3; n++) run_cycle();
        check_value("a_read_rdata", 64'(bus_a.p_rdata), 64'(32'hDEADBEEF));
        check_value("a_read_addr",  64'(bus_a.addr),    64'(26'h0000010));

        // Single write on channel 1.
        s_req[1] = 1'b1; s_we[1] = 1'b1; s_addr[1] = 26'h0000020;
        s_wdata[1] = 32'h12345678;
        run_cycle();
        s_req[1] = 1'b0;
        for (int n = 0; n < 3; n++) run_cycle();
        check_value("a_write_dout",  64'(bus_a.data_out), 64'(32'h12345678));
        check_value("a_write_rdata", 64'(bus_a.p_rdata),  64'(32'hDEADBEEF));

        // Contention: channels 0 and 1 requesting continuously.
        s_req[0] = 1'b1; s_we[0] = 1'b0;
        s_req[1] = 1'b1; s_we[1] = 1'b1;
        for (int n = 0; n < 14; n++) run_cycle();
        s_req = '0;
        for (int n = 0; n < 3; n++) run_cycle();

        // Reset during the first access cycle, then fresh requests.
        s_req[0] = 1'b1; s_we[0] = 1'b0;
        run_cycle();
        s_req[0] = 1'b0;
        pulse_reset();
        s_req = 4'b1101;
        s_we  = 4'b0000;
        s_addr[2] = 26'h0000222;
        s_addr[3] = 26'h0000333;

        // Randomized traffic with one more reset in the middle.
        for (int n = 0; n < 400; n++) begin
            update_stim();
            run_cycle();
            if (n == 200) pulse_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
